// File: rtl/des_iter_ctrl.sv
// Sequencing controller for the iterative DES/TDES datapath: handshakes a block in,
// strobes IP/key loads and 16 Feistel rounds per pass, then handshakes the result out.
// Optional triple-DES sequencing (3 passes with RELOAD) is enabled by DES_CTRL_TDES_EN.
module des_iter_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       decrypt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ld_data,
  output logic       ld_key,
  output logic [1:0] key_sel,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       last_round,
  output logic       xfer,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_RELOAD = 2'd2,
    S_DONE   = 2'd3
  } state_e;

`ifdef DES_CTRL_TDES_EN
  localparam logic [1:0] LAST_PASS = 2'd2;
`else
  localparam logic [1:0] LAST_PASS = 2'd0;
`endif

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [1:0] pass_q, pass_d;

  logic       accept;
  logic       pass_dec;
  logic       cnt_last;
  logic       more_passes;

  // Decrypt pass starts without a rotation because C/D already hold PC1(key) = K16 state.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
    logic [1:0] amt;
    case (idx)
      4'd0:                 amt = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15:    amt = 2'd1;
      default:              amt = 2'd2;
    endcase
    return amt;
  endfunction

  assign accept      = (state_q == S_IDLE) && in_valid;
  assign cnt_last    = (cnt_q == 4'd15);
  assign more_passes = (pass_q != LAST_PASS);
  // EDE for encrypt, DED for decrypt: the middle pass flips direction.
  assign pass_dec    = mode_q ^ (pass_q == 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round counter, latched mode and pass index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      mode_q <= 1'b0;
      pass_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pass_q <= pass_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    pass_d = pass_q;
    if (accept) begin
      cnt_d  = 4'd0;
      mode_d = decrypt;
      pass_d = 2'd0;
    end else if (state_q == S_ROUND) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_last && more_passes) begin
        pass_d = pass_q + 2'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_last) state_d = more_passes ? S_RELOAD : S_DONE;
      end
      S_RELOAD: state_d = S_ROUND;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ld_data    = 1'b0;
    ld_key     = 1'b0;
    key_sel    = 2'd0;
    round_en   = 1'b0;
    round_idx  = 4'd0;
    key_shift  = 2'd0;
    key_dir    = 1'b0;
    last_round = 1'b0;
    xfer       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_data = 1'b1;
          ld_key  = 1'b1;
`ifdef DES_CTRL_TDES_EN
          key_sel = decrypt ? 2'd2 : 2'd0;
`endif
        end
      end
      S_ROUND: begin
        round_en   = 1'b1;
        round_idx  = cnt_q;
        key_shift  = shift_amt(cnt_q, pass_dec);
        key_dir    = pass_dec;
        last_round = cnt_last;
      end
      S_RELOAD: begin
`ifdef DES_CTRL_TDES_EN
        xfer    = 1'b1;
        ld_key  = 1'b1;
        key_sel = mode_q ? (2'd2 - pass_q) : pass_q;
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Scoreboard bench for des_iter_ctrl: the driver queues the expected output word for
// every cycle it drives, and a negedge monitor pops and compares against the DUT.
module tb_des_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, decrypt, out_ready;
  logic       in_ready, out_valid, ld_data, ld_key, round_en, key_dir, last_round, xfer, busy;
  logic [1:0] key_sel, key_shift;
  logic [3:0] round_idx;

  int tests_run = 0;
  int tests_failed = 0;

  logic [16:0] exp_q[$];
  string       name_q[$];

  int ENC_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int DEC_SH [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

`ifdef DES_CTRL_TDES_EN
  localparam int NPASS = 3;
  localparam bit TDES  = 1'b1;
`else
  localparam int NPASS = 1;
  localparam bit TDES  = 1'b0;
`endif

  des_iter_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .ld_data(ld_data), .ld_key(ld_key),
    .key_sel(key_sel), .round_en(round_en), .round_idx(round_idx), .key_shift(key_shift),
    .key_dir(key_dir), .last_round(last_round), .xfer(xfer), .busy(busy)
  );

  always #5 clk = ~clk;

  // Word layout: in_ready,out_valid,ld_data,ld_key,key_sel[2],round_en,round_idx[4],key_shift[2],key_dir,last_round,xfer,busy
  function automatic logic [16:0] w_idle();
    return {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [16:0] w_accept(input bit dec);
    logic [1:0] ks;
    ks = (TDES && dec) ? 2'd2 : 2'd0;
    return {1'b1, 1'b0, 1'b1, 1'b1, ks, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [16:0] w_round(input int i, input bit dir);
    logic [1:0] sh;
    logic [3:0] ri;
    sh = dir ? 2'(DEC_SH[i]) : 2'(ENC_SH[i]);
    ri = 4'(i);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ri, sh, dir, (i == 15), 1'b0, 1'b1};
  endfunction

  function automatic logic [16:0] w_reload(input logic [1:0] ks);
    return {1'b0, 1'b0, 1'b0, 1'b1, ks, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic logic [16:0] w_done();
    return {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
  endfunction

  // Drive one cycle of inputs and queue that cycle's expected outputs.
  task automatic step(input bit iv, input bit dec, input bit ordy, input bit r,
                      input logic [16:0] e, input string nm);
    in_valid  = iv;
    decrypt   = dec;
    out_ready = ordy;
    rst       = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // One full block; stall = cycles out_ready is held low in DONE.
  task automatic run_block(input bit dec, input int stall, input bit tog, input string tag);
    bit hold;
    bit d2;
    hold = (stall > 0);
    d2   = tog ? ~dec : dec;
    step(1'b1, dec, 1'b1, 1'b0, w_accept(dec), {tag, " accept"});
    for (int p = 0; p < NPASS; p++) begin
      bit dir;
      dir = dec ^ (p == 1);
      for (int i = 0; i < 16; i++)
        step(hold, d2, 1'b1, 1'b0, w_round(i, dir), $sformatf("%s p%0d r%0d", tag, p, i));
      if (p < NPASS - 1) begin
        logic [1:0] ks;
        ks = dec ? 2'(1 - p) : 2'(p + 1);
        step(hold, d2, 1'b1, 1'b0, w_reload(ks), $sformatf("%s reload%0d", tag, p));
      end
    end
    for (int s = 0; s <= stall; s++)
      step(hold, d2, (s == stall), 1'b0, w_done(), $sformatf("%s done%0d", tag, s));
    step(1'b0, dec, 1'b1, 1'b0, w_idle(), {tag, " idle_after"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {in_ready, out_valid, ld_data, ld_key, key_sel, round_en, round_idx,
            key_shift, key_dir, last_round, xfer, busy};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got %b, expected %b", nm, a, e);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, 1'b1, w_idle(), "reset0");
    step(1'b0, 1'b0, 1'b1, 1'b1, w_idle(), "reset1");
    step(1'b0, 1'b0, 1'b1, 1'b0, w_idle(), "idle0");

    run_block(1'b0, 0, 1'b0, "enc");
    run_block(1'b1, 0, 1'b1, "dec_tog");
    run_block(1'b0, 5, 1'b1, "enc_stall");

    // Reset lands during round 7 of the first pass.
    step(1'b1, 1'b0, 1'b1, 1'b0, w_accept(1'b0), "rst_mid accept");
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, w_round(i, 1'b0), $sformatf("rst_mid r%0d", i));
    step(1'b0, 1'b0, 1'b1, 1'b1, w_round(7, 1'b0), "rst_mid r7");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, w_idle(), $sformatf("rst_mid idle%0d", i));

    run_block(1'b1, 2, 1'b0, "dec_stall");

    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d queued, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
